// File: rtl/ocsim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ocsim_pkg
//  Description : Shared types and helpers for the ocsim simulation arbiters.
//  Revision    : 1.0 - initial release
// ============================================================================
package ocsim_pkg;

  // Arbitration policy used when a new grant is chosen.
  typedef enum logic [0:0] {
    ArbRoundRobin    = 1'b0,
    ArbFixedPriority = 1'b1
  } ArbPolicy;

  // Index width for n requesters; never zero so a single-input arbiter
  // still has a real source-tag port.
  function automatic int unsigned src_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ocsim_arb_picker.sv
`default_nettype none
// ============================================================================
//  Module      : ocsim_arb_picker
//  Description : Combinational requester selection. Round-robin scans from
//                the index after lastGrant with wrap; fixed priority takes
//                the lowest set request bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module ocsim_arb_picker
  import ocsim_pkg::*;
#(
  parameter int unsigned NumInputs   = 4,
  parameter ArbPolicy    Policy      = ArbRoundRobin,
  parameter int unsigned SourceWidth = src_width(NumInputs)
) (
  input  logic [NumInputs-1:0]   req,
  input  logic [SourceWidth-1:0] lastGrant,
  output logic [SourceWidth-1:0] pick,
  output logic                   anyReq
);

  // Visit candidates in priority order and keep the first requester seen.
  always_comb begin
    logic                   found;
    int unsigned            idx;
    logic [SourceWidth-1:0] cand;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    pick  = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      if (Policy == ArbFixedPriority) begin
        idx = i;
      end else begin
        idx = (32'(lastGrant) + 1 + i) % NumInputs;
      end
      cand = SourceWidth'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign anyReq = |req;

endmodule
`default_nettype wire

// File: rtl/ocsim_data_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ocsim_data_arbiter
//  Description : Shares one valid/ready sink between NumInputs sources.
//                One source is granted for a burst of up to MaxBurst beats,
//                then the arbiter spends one Idle cycle choosing the next.
//                The output stage is fully registered and every beat is
//                tagged with the index of the source that supplied it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ocsim_data_arbiter
  import ocsim_pkg::*;
#(
  parameter type         Type      = logic [31:0],
  parameter int unsigned NumInputs = 4,
  parameter int unsigned MaxBurst  = 8,
  parameter ArbPolicy    Policy    = ArbRoundRobin,
  localparam int unsigned SourceWidth = src_width(NumInputs)
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  Type                    inData   [NumInputs],
  input  logic [NumInputs-1:0]   inValid,
  output logic [NumInputs-1:0]   inReady,
  input  logic [NumInputs-1:0]   inEnable,
  output Type                    outData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [SourceWidth-1:0] outSource,
  output logic                   busy
);

  localparam int unsigned CountWidth = $clog2(MaxBurst + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Last grant starts at the top index so input 0 wins the first round-robin pass.
  localparam logic [SourceWidth-1:0] LastInit = SourceWidth'(NumInputs - 1);
  localparam logic [CountWidth-1:0]  LastBeat = CountWidth'(MaxBurst - 1);

  logic [0:0]             state_q,      state_d;
  logic [SourceWidth-1:0] grant_q,      grant_d;
  logic [SourceWidth-1:0] last_grant_q, last_grant_d;
  logic [CountWidth-1:0]  beat_count_q, beat_count_d;
  Type                    out_data_q,   out_data_d;
  logic                   out_valid_q,  out_valid_d;
  logic [SourceWidth-1:0] out_source_q, out_source_d;
  logic                   busy_q,       busy_d;

  logic [NumInputs-1:0]   req;
  logic [SourceWidth-1:0] pick;
  logic                   any_req;
  logic                   load;
  logic                   grant_valid;
  logic                   xfer;

  // The enable mask only matters here, i.e. when a new grant is chosen.
  assign req = inValid & inEnable;

  ocsim_arb_picker #(
    .NumInputs  (NumInputs),
    .Policy     (Policy),
    .SourceWidth(SourceWidth)
  ) u_picker (
    .req      (req),
    .lastGrant(last_grant_q),
    .pick     (pick),
    .anyReq   (any_req)
  );

  // Output register may take a new beat when empty or being drained this cycle.
  assign load        = !out_valid_q || outReady;
  assign grant_valid = inValid[grant_q];
  assign xfer        = (state_q == ST_GRANT) && load && grant_valid;

  // Only the granted source sees ready, and only when the output can take a beat.
  always_comb begin
    inReady = '0;
    if (state_q == ST_GRANT) begin
      inReady[grant_q] = load;
    end
  end

  // Next-state logic for the grant FSM and the registered output stage.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_count_d = beat_count_q;
    busy_d       = busy_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_source_d = out_source_q;

    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d   = inData[grant_q];
        out_source_d = grant_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_GRANT;
          grant_d      = pick;
          last_grant_d = pick;
          beat_count_d = '0;
          busy_d       = 1'b1;
        end
      end
      default: begin
        if (xfer) begin
          beat_count_d = beat_count_q + CountWidth'(1);
          // Release on the last permitted beat, so the counter never wraps.
          if (beat_count_q == LastBeat) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else if (load) begin
          // Output could accept but the granted source had nothing: it ran dry.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  // State and output registers; reset drops any in-flight beat.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LastInit;
      beat_count_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_source_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_count_q <= beat_count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_source_q <= out_source_d;
      busy_q       <= busy_d;
    end
  end

  assign outData   = out_data_q;
  assign outValid  = out_valid_q;
  assign outSource = out_source_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ocsim_data_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ocsim_data_arbiter
//  Description : Self-checking bench for ocsim_data_arbiter. A round-robin
//                instance (MaxBurst=4) is driven against a transaction-level
//                model and a per-source scoreboard; a fixed-priority
//                instance covers the priority/mask behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ocsim_data_arbiter;
  import ocsim_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int SW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Round-robin instance signals
  logic [31:0]   rr_in_data [N];
  logic [N-1:0]  rr_in_valid, rr_in_ready, rr_in_enable;
  logic [31:0]   rr_out_data;
  logic          rr_out_valid, rr_out_ready, rr_busy;
  logic [SW-1:0] rr_out_source;

  // Fixed-priority instance signals
  logic [31:0]   fp_in_data [N];
  logic [N-1:0]  fp_in_valid, fp_in_ready, fp_in_enable;
  logic [31:0]   fp_out_data;
  logic          fp_out_valid, fp_out_ready, fp_busy;
  logic [SW-1:0] fp_out_source;

  ocsim_data_arbiter #(
    .Type(logic [31:0]), .NumInputs(N), .MaxBurst(MB), .Policy(ArbRoundRobin)
  ) u_dut_rr (
    .clock(clk), .resetN(rst_n),
    .inData(rr_in_data), .inValid(rr_in_valid), .inReady(rr_in_ready), .inEnable(rr_in_enable),
    .outData(rr_out_data), .outValid(rr_out_valid), .outReady(rr_out_ready),
    .outSource(rr_out_source), .busy(rr_busy)
  );

  ocsim_data_arbiter #(
    .Type(logic [31:0]), .NumInputs(N), .MaxBurst(MB), .Policy(ArbFixedPriority)
  ) u_dut_fp (
    .clock(clk), .resetN(rst_n),
    .inData(fp_in_data), .inValid(fp_in_valid), .inReady(fp_in_ready), .inEnable(fp_in_enable),
    .outData(fp_out_data), .outValid(fp_out_valid), .outReady(fp_out_ready),
    .outSource(fp_out_source), .busy(fp_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard: every accepted input beat, in acceptance order.
  typedef struct { int src; logic [31:0] data; } beat_t;
  beat_t       sent_q[$];
  logic [31:0] head [N];

  // Transaction-level model of the round-robin instance.
  bit m_busy;
  int m_grant, m_last, m_count, m_out_src;
  bit m_out_valid;

  // Observations taken just before each active edge.
  int           obs_accept;
  logic         obs_out_valid, obs_busy;
  int           obs_out_source;
  logic [N-1:0] obs_in_ready;
  logic [31:0]  obs_out_data;

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int i = 1; i <= N; i++) begin
      if (req[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_grant = 0; m_last = N - 1; m_count = 0;
    m_out_valid = 1'b0; m_out_src = 0;
    sent_q.delete();
  endtask

  // One clock of the round-robin instance: check, model, advance sources.
  task automatic cycle();
    logic [N-1:0] req, exp_ready;
    bit           load, acc;
    int           hit;
    #1;
    obs_in_ready   = rr_in_ready;
    obs_out_valid  = rr_out_valid;
    obs_out_source = int'(rr_out_source);
    obs_busy       = rr_busy;
    obs_out_data   = rr_out_data;

    load      = !m_out_valid || rr_out_ready;
    exp_ready = (m_busy && load) ? (N'(1) << m_grant) : '0;
    checks++;
    if (obs_busy !== m_busy) begin
      failures++; $display("FAIL busy t=%0t: got %b expected %b", $time, obs_busy, m_busy);
    end
    checks++;
    if (obs_in_ready !== exp_ready) begin
      failures++; $display("FAIL in_ready t=%0t: got %b expected %b", $time, obs_in_ready, exp_ready);
    end
    checks++;
    if (obs_out_valid !== m_out_valid) begin
      failures++; $display("FAIL out_valid t=%0t: got %b expected %b", $time, obs_out_valid, m_out_valid);
    end
    if (m_out_valid) begin
      checks++;
      if (obs_out_source != m_out_src) begin
        failures++; $display("FAIL out_source t=%0t: got %0d expected %0d", $time, obs_out_source, m_out_src);
      end
    end

    if (rr_out_valid === 1'b1 && rr_out_ready) begin
      hit = -1;
      foreach (sent_q[i]) if (hit < 0 && sent_q[i].src == obs_out_source) hit = i;
      checks++;
      if (hit < 0) begin
        failures++; $display("FAIL scoreboard t=%0t: beat from src %0d data %h never sent", $time, obs_out_source, obs_out_data);
      end else begin
        if (sent_q[hit].data !== obs_out_data) begin
          failures++; $display("FAIL scoreboard t=%0t: src %0d got %h expected %h", $time, obs_out_source, obs_out_data, sent_q[hit].data);
        end
        sent_q.delete(hit);
      end
    end

    obs_accept = -1;
    for (int s = 0; s < N; s++) begin
      if (rr_in_valid[s] && rr_in_ready[s]) begin
        obs_accept = (obs_accept == -1) ? s : -2;
        sent_q.push_back('{src: s, data: head[s]});
        head[s] = $urandom;
      end
    end

    acc = m_busy && load && rr_in_valid[m_grant];
    req = rr_in_valid & rr_in_enable;
    if (load) begin
      m_out_valid = acc;
      if (acc) m_out_src = m_grant;
    end
    if (!m_busy) begin
      if (req != '0) begin
        m_grant = rr_pick(req, m_last); m_last = m_grant; m_count = 0; m_busy = 1'b1;
      end
    end else if (acc) begin
      m_count++;
      if (m_count == MB) m_busy = 1'b0;
    end else if (load) begin
      m_busy = 1'b0;
    end

    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < N; s++) rr_in_data[s] = head[s];
  endtask

  // Stop all sources, let the output empty, and confirm nothing was lost.
  task automatic drain();
    rr_in_valid  = '0;
    rr_out_ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if (sent_q.size() != 0) begin
      failures++; $display("FAIL drain: %0d accepted beats never delivered, expected 0", sent_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    rr_in_valid = '1; rr_in_enable = '1; rr_out_ready = 1'b1;
    fp_in_valid = '1; fp_in_enable = '1; fp_out_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (rr_out_valid !== 1'b0 || rr_busy !== 1'b0 || rr_in_ready !== '0) begin
      failures++; $display("FAIL reset_ctrl: got valid=%b busy=%b ready=%b expected 0/0/0000", rr_out_valid, rr_busy, rr_in_ready);
    end
    checks++;
    if (rr_out_source !== '0 || rr_out_data !== '0) begin
      failures++; $display("FAIL reset_data: got src=%0d data=%h expected 0/0", rr_out_source, rr_out_data);
    end
    checks++;
    if (fp_out_valid !== 1'b0 || fp_busy !== 1'b0 || fp_in_ready !== '0) begin
      failures++; $display("FAIL reset_fp: got valid=%b busy=%b ready=%b expected 0/0/0000", fp_out_valid, fp_busy, fp_in_ready);
    end
    model_reset();
    fp_in_valid = '0;
  endtask

  // All sources valid out of reset: bursts of MB to 0,1,2,3,0 with one bubble each.
  task automatic test_round_robin();
    int exp_acc, exp_prev;
    rst_n = 1'b1;
    exp_prev = -1;
    for (int k = 0; k < 5 * (MB + 1); k++) begin
      exp_acc = (k % (MB + 1) == 0) ? -1 : (k / (MB + 1)) % N;
      cycle();
      checks++;
      if (obs_accept != exp_acc) begin
        failures++; $display("FAIL rr_accept k=%0d: got %0d expected %0d", k, obs_accept, exp_acc);
      end
      checks++;
      if (obs_out_valid !== (exp_prev >= 0) || (exp_prev >= 0 && obs_out_source != exp_prev)) begin
        failures++; $display("FAIL rr_output k=%0d: got valid=%b src=%0d expected valid=%b src=%0d",
                             k, obs_out_valid, obs_out_source, exp_prev >= 0, exp_prev);
      end
      exp_prev = exp_acc;
    end
    drain();
  endtask

  // Single requester raised before edge N: ready in cycle N+1, output after edge N+1.
  task automatic test_latency();
    rr_in_enable = '1;
    repeat (2) cycle();
    rr_in_valid = 4'b0100;
    cycle();
    checks++;
    if (obs_in_ready !== 4'b0000 || obs_busy !== 1'b0) begin
      failures++; $display("FAIL lat_arb: got ready=%b busy=%b expected 0000/0", obs_in_ready, obs_busy);
    end
    cycle();
    checks++;
    if (obs_in_ready !== 4'b0100 || obs_out_valid !== 1'b0 || obs_busy !== 1'b1) begin
      failures++; $display("FAIL lat_grant: got ready=%b valid=%b busy=%b expected 0100/0/1", obs_in_ready, obs_out_valid, obs_busy);
    end
    cycle();
    checks++;
    if (obs_out_valid !== 1'b1 || obs_out_source != 2) begin
      failures++; $display("FAIL lat_out: got valid=%b src=%0d expected 1/2", obs_out_valid, obs_out_source);
    end
    drain();
  endtask

  // Source 1 runs dry after two beats; the next pass starts after it.
  task automatic test_run_dry();
    rr_in_valid = 4'b0010;
    cycle();
    cycle();
    checks++;
    if (obs_accept != 1) begin failures++; $display("FAIL dry_beat1: got %0d expected 1", obs_accept); end
    cycle();
    checks++;
    if (obs_accept != 1) begin failures++; $display("FAIL dry_beat2: got %0d expected 1", obs_accept); end
    rr_in_valid = 4'b1100;
    cycle();
    checks++;
    if (obs_accept != -1 || obs_busy !== 1'b1) begin
      failures++; $display("FAIL dry_release: got accept=%0d busy=%b expected -1/1", obs_accept, obs_busy);
    end
    rr_in_valid = 4'b1110;
    cycle();
    checks++;
    if (obs_busy !== 1'b0) begin failures++; $display("FAIL dry_idle: got busy=%b expected 0", obs_busy); end
    cycle();
    checks++;
    if (obs_accept != 2) begin failures++; $display("FAIL dry_next: got %0d expected 2", obs_accept); end
    drain();
  endtask

  // Five stalled cycles mid-burst: output frozen, no ready, burst still exactly MB.
  task automatic test_backpressure();
    int          beats, held_src;
    logic [31:0] held_data;
    bit          ended;
    rr_in_valid = 4'b1000;
    cycle();
    beats = 0;
    repeat (2) begin cycle(); if (obs_accept == 3) beats++; end
    rr_out_ready = 1'b0;
    cycle();
    held_data = obs_out_data; held_src = obs_out_source;
    repeat (4) begin
      cycle();
      checks++;
      if (obs_out_data !== held_data || obs_out_source != held_src || obs_in_ready !== '0) begin
        failures++; $display("FAIL bp_hold: got data=%h src=%0d ready=%b expected %h/%0d/0000",
                             obs_out_data, obs_out_source, obs_in_ready, held_data, held_src);
      end
    end
    rr_out_ready = 1'b1;
    ended = 1'b0;
    for (int i = 0; i < 3 * MB && !ended; i++) begin
      cycle();
      if (obs_accept == 3) beats++;
      else if (!obs_busy) ended = 1'b1;
    end
    checks++;
    if (!ended || beats != MB) begin
      failures++; $display("FAIL bp_burst: got %0d beats (ended=%b) expected %0d", beats, ended, MB);
    end
    drain();
  endtask

  // Reset pulled mid-burst clears outputs at once; first grant afterwards is lowest valid.
  task automatic test_reset_mid_burst();
    rr_in_valid = '1;
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rr_out_valid !== 1'b0 || rr_busy !== 1'b0 || rr_in_ready !== '0) begin
      failures++; $display("FAIL async_reset: got valid=%b busy=%b ready=%b expected 0/0/0000", rr_out_valid, rr_busy, rr_in_ready);
    end
    model_reset();
    rr_in_valid = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    cycle();
    checks++;
    if (obs_accept != 1) begin failures++; $display("FAIL post_reset_grant: got %0d expected 1", obs_accept); end
    drain();
  endtask

  // Fixed priority: input 0 starves input 3 until masked off.
  task automatic test_fixed_priority();
    int  saw0;
    bit  found;
    for (int s = 0; s < N; s++) fp_in_data[s] = $urandom;
    fp_in_valid = 4'b1001; fp_in_enable = '1; fp_out_ready = 1'b1;
    saw0 = 0;
    repeat (20) begin
      cycle();
      checks++;
      if (fp_in_ready[3] !== 1'b0 || (fp_out_valid === 1'b1 && fp_out_source != 0)) begin
        failures++; $display("FAIL fp_priority: got ready=%b src=%0d expected input 0 only", fp_in_ready, fp_out_source);
      end
      if (fp_out_valid === 1'b1) saw0++;
    end
    checks++;
    if (saw0 == 0) begin failures++; $display("FAIL fp_progress: got %0d beats from input 0 expected >0", saw0); end
    fp_in_enable = 4'b1110;
    found = 1'b0;
    for (int i = 0; i < 3 * MB && !found; i++) begin
      cycle();
      if (fp_in_ready[3] === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL fp_mask: input 3 never granted, expected grant after masking 0"); end
    cycle();
    checks++;
    if (fp_out_valid !== 1'b1 || fp_out_source != 3) begin
      failures++; $display("FAIL fp_mask_out: got valid=%b src=%0d expected 1/3", fp_out_valid, fp_out_source);
    end
    fp_in_valid = '0;
  endtask

  // Random valid, mask and backpressure against the model and scoreboard.
  task automatic test_random();
    repeat (400) begin
      for (int s = 0; s < N; s++) begin
        rr_in_valid[s]  = ($urandom_range(0, 9) < 8);
        rr_in_enable[s] = ($urandom_range(0, 9) < 7);
      end
      rr_out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    rr_in_enable = '1;
    drain();
  endtask

  initial begin
    for (int s = 0; s < N; s++) begin
      head[s] = $urandom; rr_in_data[s] = head[s]; fp_in_data[s] = '0;
    end
    rr_in_valid = '0; rr_in_enable = '0; rr_out_ready = 1'b0;
    fp_in_valid = '0; fp_in_enable = '0; fp_out_ready = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_latency();
    test_run_dry();
    test_backpressure();
    test_reset_mid_burst();
    test_fixed_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ocsim_data_arbiter.md
Name: ocsim_data_arbiter

Overview:
- Shares one valid/ready sink between NumInputs valid/ready sources, e.g. several data sources feeding a single DUT port in sim.
- Grants one input at a time for a burst of up to MaxBurst beats, then re-arbitrates using the configured policy.
- Output is fully registered. outSource tags each beat with its origin input so scoreboards can demux the stream.

Parameters:
- Type, logic [31:0], payload type carried on every input and on the output.
- NumInputs, 4, number of requesters; legal range 1..16.
- MaxBurst, 8, maximum beats per grant; legal range 1..256.
- Policy, ocsim_pkg::ArbRoundRobin, arbitration policy; ArbRoundRobin or ArbFixedPriority (input 0 highest).

Ports:
- clock  input  1  single clock; all state on posedge.
- resetN  input  1  asynchronous assert, active-low reset.
- inData  input  NumInputs x Type  per-input payload.
- inValid  input  NumInputs  per-input valid.
- inReady  output  NumInputs  per-input ready.
- inEnable  input  NumInputs  requester mask; sampled only during arbitration.
- outData  output  Type  registered payload.
- outValid  output  1  registered valid.
- outReady  input  1  sink ready.
- outSource  output  SourceWidth  index of the input that supplied outData. SourceWidth = max(1, $clog2(NumInputs)).
- busy  output  1  high while any grant is held.

Behaviour:
- Reset values:
  - outValid=0, outData='0, outSource=0, busy=0, inReady=0.
  - State=Idle, beatCount=0.
  - lastGrant=NumInputs-1, so input 0 has first round-robin priority.
- Output register:
  - Loads when it is empty or being drained: load = !outValid || outReady.
  - When outValid && !outReady, outData, outValid and outSource hold stable.
- FSM has two states, Idle and Grant.
- Idle:
  - Compute req = inValid & inEnable.
  - If req==0, stay in Idle.
  - Otherwise pick an index. RoundRobin: first set bit of req scanning from lastGrant+1 with wrap. FixedPriority: lowest set bit.
  - At the clock edge: grant<=pick, lastGrant<=pick, beatCount<=0, go to Grant, busy<=1.
  - inReady is all zero while in Idle.
- Grant:
  - inReady[grant] = load. All other inReady bits = 0. This is combinational from state and outReady.
  - A transfer occurs when inValid[grant] && inReady[grant]. On transfer: outData<=inData[grant], outSource<=grant, outValid<=1, beatCount++.
  - When load is high and no transfer occurs, outValid<=0.
  - Release to Idle (busy<=0) on the edge where either:
    - a transfer occurs with beatCount==MaxBurst-1, or
    - inValid[grant]==0 while load==1 (requester ran dry).
  - beatCount width is $clog2(MaxBurst+1). It never wraps, because release occurs at MaxBurst-1.
- inEnable deasserting mid-grant does not abort the burst. The mask takes effect at the next arbitration.
- Each grant costs one Idle cycle. Peak throughput is MaxBurst/(MaxBurst+1) beats per cycle.
- Latency: inValid rises before edge N. Grant is taken at edge N. First beat is captured at edge N+1. outValid is visible after edge N+1.
- Backpressure: outReady=0 with outValid=1 holds load low, so inReady=0. No beats are lost or duplicated.
- NumInputs==1: the grant is always input 0; burst and Idle-bubble rules are unchanged.
- resetN asserted mid-burst clears everything asynchronously. An in-flight outValid beat is dropped; sources must restart.

Decomposition:
- ocsim_pkg gains an enum typedef ArbPolicy with values ArbRoundRobin and ArbFixedPriority.
- Sub-module ocsim_arb_picker: combinational. Inputs req[NumInputs], lastGrant, Policy. Outputs pick index and anyReq. Reusable by other sim arbiters.

Test Plan:
- Reset with all inputs valid, MaxBurst=4, outReady=1 -> grants 0,1,2,3,0. Each grant moves exactly 4 beats with matching outSource, followed by one outValid=0 bubble cycle.
- Only input 2 valid, raised before edge N -> inReady[2] first high in cycle N+1. outValid=1, outSource=2 after edge N+1.
- Input 1 drops inValid after 2 beats of a MaxBurst=8 grant -> FSM returns to Idle on that edge. Next grant goes to input 2 when inputs 1..3 are valid.
- outReady=0 for 5 cycles mid-burst -> outData/outSource stable, all inReady=0. No beat is lost or duplicated against a per-source scoreboard; the burst ends after exactly MaxBurst beats.
- FixedPriority with inputs 0 and 3 continuously valid -> only input 0 is ever granted. inEnable[0]=0 -> input 3 granted at the next arbitration.
- Assert resetN low mid-burst for 1 cycle -> outValid=0 and busy=0 immediately. After reset, the first grant goes to the lowest valid index.
